// File: rtl/pmem_burst_responder.sv
// Burst-mode pmem responder: 256-bit lines moved as 8 x 32-bit beats after a fixed latency.
// Optional per-byte write masking is enabled by defining PMEM_BYTE_ENABLE_EN.
module pmem_burst_responder #(
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_LINES);
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    beat_q, beat_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [AW-1:0] line_q, line_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic          resp_q, resp_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          we_s;
   logic          unused_s;

   logic [31:0]   mem_q [DEPTH_LINES*8];

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[i*8 +: 8] = new_w[i*8 +: 8];
         end
      end
      return res;
   endfunction

`ifdef PMEM_BYTE_ENABLE_EN
   assign unused_s = ^{mem_address[31:AW+5], mem_address[4:0]};
`else
   assign unused_s = ^{mem_address[31:AW+5], mem_address[4:0], mem_byte_enable};
`endif

   // Control registers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         beat_q  <= 3'd0;
         lat_q   <= '0;
         line_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         line_q  <= line_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic; read data for the next strobe is fetched one cycle ahead.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lat_d   = lat_q;
      line_d  = line_q;
      wr_d    = wr_q;
      err_d   = err_q;
      resp_d  = 1'b0;
      rdata_d = rdata_q;
      we_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               line_d  = mem_address[AW+4:5];
               // A simultaneous read/write request is served as a read.
               wr_d    = mem_write & ~mem_read;
               lat_d   = '0;
               state_d = ST_WAIT;
               if (mem_read && mem_write) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = ST_BURST;
               beat_d  = 3'd0;
               resp_d  = 1'b1;
               if (!wr_q) begin
                  rdata_d = mem_q[{line_q, 3'd0}];
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         ST_BURST: begin
            we_s = wr_q;
            if (beat_q == 3'd7) begin
               state_d = ST_DONE;
               beat_d  = 3'd0;
            end else begin
               beat_d = beat_q + 3'd1;
               resp_d = 1'b1;
               if (!wr_q) begin
                  rdata_d = mem_q[{line_q, beat_q + 3'd1}];
               end else begin
                  rdata_d = rdata_q;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Word storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
`ifdef PMEM_BYTE_ENABLE_EN
         mem_q[{line_q, beat_q}] <= merge_bytes(mem_q[{line_q, beat_q}], mem_wdata, mem_byte_enable);
`else
         mem_q[{line_q, beat_q}] <= merge_bytes(mem_q[{line_q, beat_q}], mem_wdata, 4'b1111);
`endif
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_resp  = resp_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed self-checking bench for pmem_burst_responder (LATENCY=4, DEPTH_LINES=256).
module tb_pmem_burst_responder;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        err;

   int checks;
   int failures;

   logic [31:0] wbuf  [8];
   logic [3:0]  bebuf [8];
   logic [31:0] rbuf  [8];
   int          nbeats;
   int          first_n;
   int          last_n;

   pmem_burst_responder #(
      .DEPTH_LINES(256),
      .LATENCY    (LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_wdata      (mem_wdata),
      .mem_byte_enable(mem_byte_enable),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One burst: drives wbuf/bebuf per strobe, records rbuf; optional early drop or reset abort.
   task automatic do_burst(input logic [31:0] addr, input logic rd, input logic wr,
                           input int drop_after, input int abort_after);
      int  n;
      bit  done;
      @(negedge clk);
      mem_address     = addr;
      mem_read        = rd;
      mem_write       = wr;
      mem_wdata       = wbuf[0];
      mem_byte_enable = bebuf[0];
      nbeats  = 0;
      first_n = -1;
      last_n  = -1;
      done    = 1'b0;
      n       = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         if (mem_resp) begin
            if (first_n < 0) first_n = n;
            last_n = n;
            if (abort_after >= 0 && nbeats == abort_after) begin
               rst = 1'b0;
               #1;
               check_eq("resp_on_reset", 32'(mem_resp), 32'd0);
               check_eq("rdata_on_reset", mem_rdata, 32'd0);
               mem_read  = 1'b0;
               mem_write = 1'b0;
               repeat (2) @(negedge clk);
               rst  = 1'b1;
               done = 1'b1;
            end else begin
               rbuf[nbeats]    = mem_rdata;
               mem_wdata       = wbuf[nbeats];
               mem_byte_enable = bebuf[nbeats];
               nbeats++;
               if (drop_after >= 0 && nbeats == drop_after) begin
                  mem_read  = 1'b0;
                  mem_write = 1'b0;
               end
            end
         end else if (nbeats > 0) begin
            done = 1'b1;
         end
         n++;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (!done) check_eq("burst_timeout", 32'(n), 32'd0);
   endtask

   task automatic fill_wbuf(input logic [31:0] base);
      for (int k = 0; k < 8; k++) begin
         wbuf[k]  = base + 32'(k);
         bebuf[k] = 4'b1111;
      end
   endtask

   initial begin
      int          resp_cnt;
      logic [31:0] exp_w0;
      checks          = 0;
      failures        = 0;
      rst             = 1'b0;
      mem_address     = 32'd0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_wdata       = 32'd0;
      mem_byte_enable = 4'b1111;
      fill_wbuf(32'd0);

      // Reset then idle
      repeat (3) @(negedge clk);
      check_eq("rst_resp", 32'(mem_resp), 32'd0);
      check_eq("rst_rdata", mem_rdata, 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      rst = 1'b1;
      resp_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_resp) resp_cnt++;
      end
      check_eq("idle_no_resp", 32'(resp_cnt), 32'd0);

      // Write line 0x40 then read it back, with strobe timing
      fill_wbuf(32'h1000_0000);
      do_burst(32'h0000_0040, 1'b0, 1'b1, -1, -1);
      check_eq("wr_first_resp", 32'(first_n), 32'(LAT));
      check_eq("wr_last_resp", 32'(last_n), 32'(LAT + 7));
      check_eq("wr_nbeats", 32'(nbeats), 32'd8);
      do_burst(32'h0000_0040, 1'b1, 1'b0, -1, -1);
      check_eq("rd_first_resp", 32'(first_n), 32'(LAT));
      check_eq("rd_nbeats", 32'(nbeats), 32'd8);
      for (int k = 0; k < 8; k++) check_eq($sformatf("rd40_b%0d", k), rbuf[k], 32'h1000_0000 + 32'(k));
      repeat (3) @(negedge clk);
      check_eq("rdata_hold", mem_rdata, 32'h1000_0007);

      // Address wrap and ignored low bits
      fill_wbuf(32'h2000_0000);
      do_burst(32'h0000_2000, 1'b0, 1'b1, -1, -1);
      do_burst(32'h0000_001F, 1'b1, 1'b0, -1, -1);
      for (int k = 0; k < 8; k++) check_eq($sformatf("wrap_b%0d", k), rbuf[k], 32'h2000_0000 + 32'(k));
      do_burst(32'h0000_0040, 1'b1, 1'b0, -1, -1);
      check_eq("line2_intact", rbuf[5], 32'h1000_0005);

      // Byte-enable masking on beat 0 of line 0
      fill_wbuf(32'h4000_0000);
      wbuf[0] = 32'hAABB_CCDD;
      do_burst(32'h0000_0000, 1'b0, 1'b1, -1, -1);
      wbuf[0]  = 32'h1122_3344;
      bebuf[0] = 4'b0101;
      do_burst(32'h0000_0000, 1'b0, 1'b1, -1, -1);
      do_burst(32'h0000_0000, 1'b1, 1'b0, -1, -1);
`ifdef PMEM_BYTE_ENABLE_EN
      exp_w0 = 32'hAA22_CC44;
`else
      exp_w0 = 32'h1122_3344;
`endif
      check_eq("be_word0", rbuf[0], exp_w0);
      check_eq("be_word3", rbuf[3], 32'h4000_0003);

      // Simultaneous read and write: served as a read, err sticky
      fill_wbuf(32'hDEAD_0000);
      check_eq("err_before", 32'(err), 32'd0);
      do_burst(32'h0000_0040, 1'b1, 1'b1, -1, -1);
      check_eq("rw_nbeats", 32'(nbeats), 32'd8);
      for (int k = 0; k < 8; k++) check_eq($sformatf("rw_b%0d", k), rbuf[k], 32'h1000_0000 + 32'(k));
      check_eq("err_set", 32'(err), 32'd1);

      // Read dropped after beat 2 still delivers 8 beats
      do_burst(32'h0000_0040, 1'b1, 1'b0, 3, -1);
      check_eq("drop_nbeats", 32'(nbeats), 32'd8);
      check_eq("drop_b7", rbuf[7], 32'h1000_0007);
      check_eq("err_sticky", 32'(err), 32'd1);

      // Reset after write beat 3 aborts the burst
      fill_wbuf(32'h3000_0000);
      do_burst(32'h0000_0040, 1'b0, 1'b1, -1, 4);
      check_eq("err_cleared", 32'(err), 32'd0);
      do_burst(32'h0000_0040, 1'b1, 1'b0, -1, -1);
      for (int k = 0; k < 4; k++) check_eq($sformatf("abort_new_b%0d", k), rbuf[k], 32'h3000_0000 + 32'(k));
      for (int k = 4; k < 8; k++) check_eq($sformatf("abort_old_b%0d", k), rbuf[k], 32'h1000_0000 + 32'(k));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
